// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: EX-stage branch resolution, redirect FSM, 2-entry predictor update FIFO, counters
module branch_resolve_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_br,
  input  logic        ex_stall,
  input  logic [31:0] ex_brPC,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  input  logic        ex_act_taken,
  input  logic [31:0] ex_act_target,
  input  logic        if_ready,
  input  logic        upd_ready,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_PC,
  output logic        ex_hold,
  output logic        upd_valid,
  output logic [31:0] upd_PC,
  output logic [31:0] upd_target,
  output logic        upd_taken,
  output logic [15:0] br_count,
  output logic [15:0] mp_count
);
  typedef enum logic {IDLE, REDIRECT} state_t;
  state_t state, state_n;
  logic [31:0] pc_q [2];
  logic [31:0] tgt_q [2];
  logic [1:0]  tk_q;
  logic        wr_ptr, rd_ptr;
  logic [1:0]  cnt;
  logic        idle, full, accept, mispredict, pop;
  logic [31:0] correct_pc;

  // acceptance, mispredict detection, FIFO head and FSM next state
  always_comb begin
    idle       = state == IDLE;
    full       = cnt == 2'd2;
    ex_hold    = ex_br & ~ex_stall & full & idle;
    accept     = ex_br & ~ex_stall & ~full & idle;
    mispredict = (ex_pred_taken != ex_act_taken) | (ex_act_taken & (ex_pred_target != ex_act_target));
    correct_pc = ex_act_taken ? ex_act_target : ex_brPC + 32'd4;
    upd_valid  = cnt != 2'd0;
    pop        = upd_valid & upd_ready;
    upd_PC     = pc_q[rd_ptr];
    upd_target = tgt_q[rd_ptr];
    upd_taken  = tk_q[rd_ptr];
    flush      = ~idle;
    redirect   = ~idle;
    state_n    = idle ? ((accept & mispredict) ? REDIRECT : IDLE) : (if_ready ? IDLE : REDIRECT);
  end

  // redirect FSM state and captured correct PC
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      redirect_PC <= '0;
    end else begin
      state <= state_n;
      if (accept & mispredict) redirect_PC <= correct_pc;
    end
  end

  // update FIFO: push accepted branches, pop on handshake
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q[0]  <= '0;
      pc_q[1]  <= '0;
      tgt_q[0] <= '0;
      tgt_q[1] <= '0;
      tk_q     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        pc_q[wr_ptr]  <= ex_brPC;
        tgt_q[wr_ptr] <= ex_act_target;
        tk_q[wr_ptr]  <= ex_act_taken;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(accept) - 2'(pop);
    end
  end

  // saturating branch and mispredict counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      br_count <= '0;
      mp_count <= '0;
    end else begin
      if (accept && br_count != 16'hFFFF) br_count <= br_count + 16'd1;
      if (accept && mispredict && mp_count != 16'hFFFF) mp_count <= mp_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: vector table, directed sequences and random stimulus against a queue model
module tb_branch_resolve_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        ex_br = 1'b0, ex_stall = 1'b0, ex_pred_taken = 1'b0, ex_act_taken = 1'b0;
  logic [31:0] ex_brPC = '0, ex_pred_target = '0, ex_act_target = '0;
  logic        if_ready = 1'b0, upd_ready = 1'b0;
  logic        flush, redirect, ex_hold, upd_valid, upd_taken;
  logic [31:0] redirect_PC, upd_PC, upd_target;
  logic [15:0] br_count, mp_count;

  branch_resolve_ctrl dut (
    .CLK(CLK), .RST(RST), .ex_br(ex_br), .ex_stall(ex_stall), .ex_brPC(ex_brPC),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .ex_act_taken(ex_act_taken), .ex_act_target(ex_act_target),
    .if_ready(if_ready), .upd_ready(upd_ready), .flush(flush), .redirect(redirect),
    .redirect_PC(redirect_PC), .ex_hold(ex_hold), .upd_valid(upd_valid), .upd_PC(upd_PC),
    .upd_target(upd_target), .upd_taken(upd_taken), .br_count(br_count), .mp_count(mp_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc, tgt;
    logic        tk;
  } upd_t;
  upd_t        mq [$];
  logic        mbusy;
  logic [31:0] mrpc;
  int          mbrc, mmpc;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    logic        br, st, ptk;
    logic [31:0] ptg;
    logic        atk;
    logic [31:0] atg, pc;
    logic        ifr, ur, e_fl;
    logic [31:0] e_rpc;
    logic        e_hold, e_uv;
    logic [15:0] e_brc, e_mpc;
  } vec_t;
  vec_t tbl [14];

  function automatic vec_t mk(logic br, st, ptk, logic [31:0] ptg, logic atk, logic [31:0] atg, pc,
                              logic ifr, ur, e_fl, logic [31:0] e_rpc, logic e_hold, e_uv,
                              logic [15:0] e_brc, e_mpc);
    vec_t v;
    v.br = br; v.st = st; v.ptk = ptk; v.ptg = ptg; v.atk = atk; v.atg = atg; v.pc = pc;
    v.ifr = ifr; v.ur = ur; v.e_fl = e_fl; v.e_rpc = e_rpc; v.e_hold = e_hold; v.e_uv = e_uv;
    v.e_brc = e_brc; v.e_mpc = e_mpc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic mreset();
    mq.delete();
    mbusy = 1'b0;
    mrpc  = '0;
    mbrc  = 0;
    mmpc  = 0;
  endtask

  task automatic mcheck();
    chk("flush", 32'(flush), 32'(mbusy));
    chk("redirect", 32'(redirect), 32'(mbusy));
    chk("redirect_PC", redirect_PC, mrpc);
    chk("upd_valid", 32'(upd_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("upd_PC", upd_PC, mq[0].pc);
      chk("upd_target", upd_target, mq[0].tgt);
      chk("upd_taken", 32'(upd_taken), 32'(mq[0].tk));
    end
    chk("ex_hold", 32'(ex_hold), 32'(ex_br && !ex_stall && mq.size() == 2 && !mbusy));
    chk("br_count", 32'(br_count), 32'(mbrc));
    chk("mp_count", 32'(mp_count), 32'(mmpc));
  endtask

  task automatic drive(input logic br, st, ptk, input logic [31:0] ptg, input logic atk,
                       input logic [31:0] atg, pc, input logic ifr, ur);
    ex_br = br; ex_stall = st; ex_pred_taken = ptk; ex_pred_target = ptg;
    ex_act_taken = atk; ex_act_target = atg; ex_brPC = pc; if_ready = ifr; upd_ready = ur;
    #1;
  endtask

  task automatic tick();
    logic acc, mp;
    upd_t e;
    @(posedge CLK);
    acc = ex_br && !ex_stall && !mbusy && mq.size() < 2;
    mp  = (ex_pred_taken != ex_act_taken) || (ex_act_taken && ex_pred_target != ex_act_target);
    if (mq.size() != 0 && upd_ready) void'(mq.pop_front());
    if (acc) begin
      e.pc = ex_brPC; e.tgt = ex_act_target; e.tk = ex_act_taken;
      mq.push_back(e);
      if (mbrc < 65535) mbrc++;
      if (mp) begin
        if (mmpc < 65535) mmpc++;
        mbusy = 1'b1;
        mrpc  = ex_act_taken ? ex_act_target : ex_brPC + 32'd4;
      end
    end else if (mbusy && if_ready) mbusy = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    RST = 1'b1;
    #1;
    mreset();
    chk("rst_pcs", redirect_PC | upd_PC | upd_target, 32'h0);
    chk("rst_bits", 32'({flush, redirect, ex_hold, upd_valid, upd_taken}), 32'h0);
    chk("rst_counts", {br_count, mp_count}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic cbr(input logic [31:0] pc, input logic ur);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, pc, 1'b1, ur);
  endtask

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 32'h100,      1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 16'd0, 16'd0);
    tbl[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 1'b1, 16'd1, 16'd1);
    tbl[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 16'd1, 16'd1);
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0,   32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 16'd1, 16'd1);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 1'b1, 16'd2, 16'd2);
    tbl[5]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h600, 32'h500,      1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 16'd2, 16'd2);
    tbl[6]  = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h600, 32'h500,      1'b0, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 16'd2, 16'd2);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 32'h0,   1'b0, 1'b0, 16'd2, 16'd2);
    tbl[8]  = mk(1'b1, 1'b0, 1'b1, 32'h300, 1'b1, 32'h340, 32'h40,       1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 16'd2, 16'd2);
    tbl[9]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b1, 32'h340, 1'b0, 1'b1, 16'd3, 16'd3);
    tbl[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h80,       1'b1, 1'b1, 1'b0, 32'h340, 1'b0, 1'b0, 16'd3, 16'd3);
    tbl[11] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 32'h340, 1'b0, 1'b1, 16'd4, 16'd3);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h700, 32'h90,       1'b1, 1'b1, 1'b0, 32'h340, 1'b0, 1'b0, 16'd4, 16'd3);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h0,        1'b1, 1'b1, 1'b0, 32'h340, 1'b0, 1'b0, 16'd4, 16'd3);

    @(negedge CLK);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].br, tbl[i].st, tbl[i].ptk, tbl[i].ptg, tbl[i].atk, tbl[i].atg, tbl[i].pc, tbl[i].ifr, tbl[i].ur);
      mcheck();
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].e_fl));
      chk($sformatf("v%0d_rpc", i), redirect_PC, tbl[i].e_rpc);
      chk($sformatf("v%0d_hold", i), 32'(ex_hold), 32'(tbl[i].e_hold));
      chk($sformatf("v%0d_uv", i), 32'(upd_valid), 32'(tbl[i].e_uv));
      chk($sformatf("v%0d_cnt", i), {br_count, mp_count}, {tbl[i].e_brc, tbl[i].e_mpc});
      if (i == 9) chk("v9_upd_taken", 32'(upd_taken), 32'h1);
      tick();
    end

    cbr(32'h1000, 1'b0); mcheck(); chk("full_a_hold", 32'(ex_hold), 32'h0); tick();
    cbr(32'h1004, 1'b0); mcheck(); chk("full_b_hold", 32'(ex_hold), 32'h0); tick();
    cbr(32'h1008, 1'b0); mcheck(); chk("full_c_hold", 32'(ex_hold), 32'h1); chk("full_head_a", upd_PC, 32'h1000); tick();
    cbr(32'h1008, 1'b1); mcheck(); chk("full_c_hold2", 32'(ex_hold), 32'h1); tick();
    cbr(32'h1008, 1'b0); mcheck(); chk("full_c_acc", 32'(ex_hold), 32'h0); chk("full_head_b", upd_PC, 32'h1004); tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1); mcheck(); chk("order_b", upd_PC, 32'h1004); tick();
    mcheck(); chk("order_c", upd_PC, 32'h1008); chk("cnt_c", 32'(br_count), 32'd7); tick();
    mcheck(); chk("drained", 32'(upd_valid), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic atk;
      logic [31:0] atg;
      atk = 1'($urandom);
      atg = $urandom & 32'hFFF0;
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
            $urandom_range(0, 3) == 0 ? ~atk : atk, $urandom_range(0, 3) == 0 ? atg ^ 32'h40 : atg,
            atk, atg, $urandom_range(0, 9) == 0 ? 32'hFFFFFFFC : $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
      mcheck();
      tick();
    end

    do_reset();
    cbr(32'h2000, 1'b1);
    repeat (65535) tick();
    mcheck();
    chk("sat_br", 32'(br_count), 32'hFFFF);
    tick(); tick();
    mcheck();
    chk("sat_br_hold", 32'(br_count), 32'hFFFF);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3000, 32'h2000, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    mcheck();
    chk("pre_rst_flush", 32'(flush), 32'h1);
    #2;
    RST = 1'b1;
    #1;
    mreset();
    chk("async_bits", 32'({flush, redirect, ex_hold, upd_valid, upd_taken}), 32'h0);
    chk("async_pcs", redirect_PC | upd_PC | upd_target, 32'h0);
    chk("async_counts", {br_count, mp_count}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    cbr(32'h4000, 1'b0);
    mcheck();
    tick();
    mcheck();
    chk("post_rst_uv", 32'(upd_valid), 32'h1);
    chk("post_rst_brc", 32'(br_count), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
